// File: rtl/mat_mac_stream.sv
// rtl/mat_mac_stream.sv - streaming NxN signed matrix multiply-accumulate engine
// Define MAT_MAC_STREAM_SAT_EN for saturating accumulation with a sticky sat flag.
module mat_mac_stream #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 32,
  parameter int N     = 4
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N-1:0][N-1:0][W_IN-1:0]       matrix_1,
  input  logic [N-1:0][N-1:0][W_IN-1:0]       matrix_2,
  input  logic                                acc_en,
  input  logic                                clear,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N-1:0][N-1:0][W_OUT-1:0]      result,
  output logic                                sat
);
  localparam int D  = $clog2(N);
  localparam int NE = N * N;
  // Per result element: N product slots followed by each adder-tree level.
  localparam int NT = 2 * N - 1;

  if (W_OUT < 2 * W_IN + D) begin : g_chk_width
    $error("mat_mac_stream: W_OUT must be at least 2*W_IN + clog2(N)");
  end
  if (N < 2 || (1 << D) != N) begin : g_chk_n
    $error("mat_mac_stream: N must be a power of two, at least 2");
  end

  function automatic logic signed [W_OUT-1:0] sext(input logic [W_IN-1:0] v);
    return {{(W_OUT - W_IN){v[W_IN-1]}}, v};
  endfunction

  logic                              enable;
  logic                              out_valid_q, out_valid_d;
  logic [D:0]                        vld_q, acc_q;
  logic [NE-1:0][NT-1:0][W_OUT-1:0]  tree_q, tree_d;
  logic [NE-1:0][W_OUT-1:0]          res_q, res_d, acc_val, wr_val;
  logic                              a_write, a_acc;

  assign enable   = !out_valid_q || out_ready;
  assign in_ready = enable;
  assign a_write  = enable && vld_q[D];
  // A clear landing on a stage-A write turns that write into a load.
  assign a_acc    = acc_q[D] && !clear;

`ifdef MAT_MAC_STREAM_SAT_EN
  localparam logic [W_OUT-1:0] SAT_MAX = {1'b0, {(W_OUT - 1){1'b1}}};
  localparam logic [W_OUT-1:0] SAT_MIN = {1'b1, {(W_OUT - 1){1'b0}}};
  logic [NE-1:0] ovf;
`endif

  for (genvar p = 0; p < NE; p++) begin : g_elem
    logic [W_OUT-1:0] tsum;

    for (genvar k = 0; k < N; k++) begin : g_mul
      assign tree_d[p][k] = sext(matrix_1[p / N][k]) * sext(matrix_2[k][p % N]);
    end

    for (genvar l = 1; l <= D; l++) begin : g_lvl
      localparam int OI = NT + 1 - ((2 * N) >> (l - 1));
      localparam int OO = NT + 1 - ((2 * N) >> l);
      for (genvar t = 0; t < (N >> l); t++) begin : g_add
        assign tree_d[p][OO + t] = tree_q[p][OI + 2 * t] + tree_q[p][OI + 2 * t + 1];
      end
    end

    assign tsum = tree_q[p][NT-1];

`ifdef MAT_MAC_STREAM_SAT_EN
    logic [W_OUT:0] wide;
    assign wide       = {res_q[p][W_OUT-1], res_q[p]} + {tsum[W_OUT-1], tsum};
    assign ovf[p]     = wide[W_OUT] ^ wide[W_OUT-1];
    assign acc_val[p] = !ovf[p] ? wide[W_OUT-1:0] : (wide[W_OUT] ? SAT_MIN : SAT_MAX);
`else
    assign acc_val[p] = res_q[p] + tsum;
`endif

    assign wr_val[p] = a_acc ? acc_val[p] : tsum;
  end

  // Tree datapath carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (enable) begin
      tree_q <= tree_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      acc_q <= '0;
    end else if (enable) begin
      vld_q <= {vld_q[D-1:0], in_valid};
      acc_q <= {acc_q[D-1:0], acc_en};
    end
  end

  always_comb begin
    res_d = res_q;
    if (clear) begin
      res_d = '0;
    end
    if (a_write) begin
      res_d = wr_val;
    end
    out_valid_d = out_valid_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (a_write) begin
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = res_q;
  assign out_valid = out_valid_q;

`ifdef MAT_MAC_STREAM_SAT_EN
  logic sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (a_write && a_acc && |ovf) begin
      sat_d = 1'b1;
    end
    if (clear) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_mat_mac_stream.sv
// tb/tb_mat_mac_stream.sv - scoreboard bench for mat_mac_stream (three parameter sets)
`timescale 1ns/1ps
module tb_mat_mac_stream;

`ifdef MAT_MAC_STREAM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // A: N=2, W_IN=8, W_OUT=32
  logic a_in_valid, a_in_ready, a_acc_en, a_clear, a_out_valid, a_out_ready, a_sat;
  logic [1:0][1:0][7:0]  a_m1, a_m2;
  logic [1:0][1:0][31:0] a_result;
  // B: N=4, W_IN=8, W_OUT=32
  logic b_in_valid, b_in_ready, b_acc_en, b_clear, b_out_valid, b_out_ready, b_sat;
  logic [3:0][3:0][7:0]  b_m1, b_m2;
  logic [3:0][3:0][31:0] b_result;
  // C: N=2, W_IN=4, W_OUT=10
  logic c_in_valid, c_in_ready, c_acc_en, c_clear, c_out_valid, c_out_ready, c_sat;
  logic [1:0][1:0][3:0]  c_m1, c_m2;
  logic [1:0][1:0][9:0]  c_result;

  mat_mac_stream #(.W_IN(8), .W_OUT(32), .N(2)) u_a (
    .clk(clk), .resetn(resetn), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .matrix_1(a_m1), .matrix_2(a_m2), .acc_en(a_acc_en), .clear(a_clear),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .result(a_result), .sat(a_sat));

  mat_mac_stream #(.W_IN(8), .W_OUT(32), .N(4)) u_b (
    .clk(clk), .resetn(resetn), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .matrix_1(b_m1), .matrix_2(b_m2), .acc_en(b_acc_en), .clear(b_clear),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result), .sat(b_sat));

  mat_mac_stream #(.W_IN(4), .W_OUT(10), .N(2)) u_c (
    .clk(clk), .resetn(resetn), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .matrix_1(c_m1), .matrix_2(c_m2), .acc_en(c_acc_en), .clear(c_clear),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .result(c_result), .sat(c_sat));

  logic [127:0] qa_res[$]; bit qa_sat[$]; int qa_cyc[$];
  logic [511:0] qb_res[$]; bit qb_sat[$]; int qb_cyc[$];
  logic [39:0]  qc_res[$]; bit qc_sat[$]; int qc_cyc[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && a_out_valid && a_out_ready) begin
      if (qa_res.size() == 0) chk("a_unexpected_out", a_out_valid, 0);
      else begin
        chk("a_result", a_result, qa_res.pop_front());
        chk("a_sat", a_sat, qa_sat.pop_front());
        chk("a_cycle", cyc, qa_cyc.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && b_out_valid && b_out_ready) begin
      if (qb_res.size() == 0) chk("b_unexpected_out", b_out_valid, 0);
      else begin
        chk("b_result", b_result, qb_res.pop_front());
        chk("b_sat", b_sat, qb_sat.pop_front());
        chk("b_cycle", cyc, qb_cyc.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && c_out_valid && c_out_ready) begin
      if (qc_res.size() == 0) chk("c_unexpected_out", c_out_valid, 0);
      else begin
        chk("c_result", c_result, qc_res.pop_front());
        chk("c_sat", c_sat, qc_sat.pop_front());
        chk("c_cycle", cyc, qc_cyc.pop_front());
      end
    end
  end

  function automatic logic [1:0][1:0][7:0] a_mat(input int e00, e01, e10, e11);
    logic [1:0][1:0][7:0] m;
    m[0][0] = e00[7:0]; m[0][1] = e01[7:0]; m[1][0] = e10[7:0]; m[1][1] = e11[7:0];
    return m;
  endfunction

  function automatic logic [1:0][1:0][31:0] a_res(input int e00, e01, e10, e11);
    logic [1:0][1:0][31:0] m;
    m[0][0] = e00; m[0][1] = e01; m[1][0] = e10; m[1][1] = e11;
    return m;
  endfunction

  function automatic logic [1:0][1:0][3:0] c_in(input int v);
    logic [1:0][1:0][3:0] m;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) m[r][c] = v[3:0];
    return m;
  endfunction

  function automatic logic [1:0][1:0][9:0] c_out(input int v);
    logic [1:0][1:0][9:0] m;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) m[r][c] = v[9:0];
    return m;
  endfunction

  // Transaction k on B: diag(k+1) x M with M[r][c] = 4r+c+k, so result = (k+1)*(4r+c+k).
  task automatic b_load(input int k);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      b_m1[r][c] = (r == c) ? 8'(k + 1) : 8'd0;
      b_m2[r][c] = 8'(4 * r + c + k);
    end
  endtask

  function automatic logic [3:0][3:0][31:0] b_expect(input int k);
    logic [3:0][3:0][31:0] e;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) e[r][c] = (k + 1) * (4 * r + c + k);
    return e;
  endfunction

  task automatic a_send(input logic [1:0][1:0][7:0] m1, input logic [1:0][1:0][7:0] m2,
                        input logic acc, input logic [1:0][1:0][31:0] exp);
    a_m1 = m1; a_m2 = m2; a_acc_en = acc; a_in_valid = 1'b1;
    qa_res.push_back(exp); qa_sat.push_back(1'b0); qa_cyc.push_back(cyc + 3);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic c_send(input int a, input int b, input logic acc, input int exp_v, input logic exp_s);
    c_m1 = c_in(a); c_m2 = c_in(b); c_acc_en = acc; c_in_valid = 1'b1;
    qc_res.push_back(c_out(exp_v)); qc_sat.push_back(exp_s); qc_cyc.push_back(cyc + 3);
    @(posedge clk); #1;
    c_in_valid = 1'b0;
  endtask

  int b_hs [6] = '{7, 8, 9, 10, 11, 12};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nxt;
    resetn = 1'b0;
    a_in_valid = 0; a_acc_en = 0; a_clear = 0; a_out_ready = 1; a_m1 = '0; a_m2 = '0;
    b_in_valid = 0; b_acc_en = 0; b_clear = 0; b_out_ready = 1; b_m1 = '0; b_m2 = '0;
    c_in_valid = 0; c_acc_en = 0; c_clear = 0; c_out_ready = 1; c_m1 = '0; c_m2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_valid", a_out_valid, 0); chk("a_rst_ready", a_in_ready, 1);
    chk("a_rst_result", a_result, 0);   chk("a_rst_sat", a_sat, 0);
    chk("b_rst_valid", b_out_valid, 0); chk("b_rst_ready", b_in_ready, 1);
    chk("b_rst_result", b_result, 0);   chk("b_rst_sat", b_sat, 0);
    chk("c_rst_valid", c_out_valid, 0); chk("c_rst_ready", c_in_ready, 1);
    chk("c_rst_result", c_result, 0);   chk("c_rst_sat", c_sat, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // A: identity load then accumulate, one cycle apart
    a_send(a_mat(1, 0, 0, 1), a_mat(1, 2, 3, 4), 1'b0, a_res(1, 2, 3, 4));
    a_send(a_mat(1, 0, 0, 1), a_mat(1, 2, 3, 4), 1'b1, a_res(2, 4, 6, 8));
    repeat (4) @(posedge clk); #1;
    // A: signed extremes, (-128)*(-128)*2 = 32768
    a_send(a_mat(-128, -128, -128, -128), a_mat(-128, -128, -128, -128), 1'b0,
           a_res(32768, 32768, 32768, 32768));
    repeat (4) @(posedge clk); #1;
    // A: clear collides with an accumulate write onto result = 50
    a_send(a_mat(5, 0, 0, 5), a_mat(10, 10, 10, 10), 1'b0, a_res(50, 50, 50, 50));
    a_send(a_mat(1, 0, 0, 1), a_mat(1, 2, 3, 4), 1'b1, a_res(1, 2, 3, 4));
    @(posedge clk); #1;
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
    repeat (4) @(posedge clk); #1;

    // B: six back-to-back loads, out_ready low for 3 cycles from first out_valid
    base = cyc;
    nxt  = 0;
    b_acc_en = 1'b0;
    for (int t = 0; t < 16; t++) begin
      b_out_ready = !(t >= 4 && t <= 6);
      if (nxt < 6) begin
        b_load(nxt);
        b_in_valid = 1'b1;
      end else begin
        b_in_valid = 1'b0;
      end
      @(negedge clk);
      if (t >= 4 && t <= 6) begin
        chk("b_stall_in_ready", b_in_ready, 0);
        chk("b_stall_hold", b_result, b_expect(0));
      end
      if (b_in_valid && b_in_ready) begin
        qb_res.push_back(b_expect(nxt)); qb_sat.push_back(1'b0); qb_cyc.push_back(base + b_hs[nxt]);
        nxt++;
      end
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;

    // C: clear while a result is held keeps out_valid
    c_out_ready = 1'b0;
    c_m1 = c_in(1); c_m2 = c_in(1); c_acc_en = 1'b0; c_in_valid = 1'b1;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("c_held_valid", c_out_valid, 1);
    chk("c_held_result", c_result, c_out(2));
    c_clear = 1'b1;
    @(posedge clk); #1;
    c_clear = 1'b0;
    chk("c_clear_result", c_result, 0);
    chk("c_clear_keeps_valid", c_out_valid, 1);
    qc_res.push_back(c_out(0)); qc_sat.push_back(1'b0); qc_cyc.push_back(cyc);
    c_out_ready = 1'b1;
    @(posedge clk); #1;

    // C: positive overflow, each sum = 128
    c_send(-8, -8, 1'b1, 128, 1'b0);
    c_send(-8, -8, 1'b1, 256, 1'b0);
    c_send(-8, -8, 1'b1, 384, 1'b0);
    c_send(-8, -8, 1'b1, SAT ? 511 : -512, SAT);
    c_send(-8, -8, 1'b1, SAT ? 511 : -384, SAT);
    repeat (4) @(posedge clk); #1;
    c_clear = 1'b1;
    @(posedge clk); #1;
    c_clear = 1'b0;
    chk("c_clear_sat", c_sat, 0);
    chk("c_clear_result2", c_result, 0);
    // C: negative overflow, each sum = -112
    c_send(-8, 7, 1'b1, -112, 1'b0);
    c_send(-8, 7, 1'b1, -224, 1'b0);
    c_send(-8, 7, 1'b1, -336, 1'b0);
    c_send(-8, 7, 1'b1, -448, 1'b0);
    c_send(-8, 7, 1'b1, SAT ? -512 : 464, SAT);
    c_send(1, 1, 1'b0, 2, SAT);
    repeat (4) @(posedge clk); #1;

    // B: reset with three transactions in flight behind a fresh result
    for (int t = 0; t < 4; t++) begin
      b_load(t);
      b_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    chk("b_prereset_valid", b_out_valid, 1);
    resetn = 1'b0;
    #1;
    chk("b_reset_valid", b_out_valid, 0);
    chk("b_reset_result", b_result, 0);
    chk("b_reset_sat", b_sat, 0);
    chk("b_reset_ready", b_in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    repeat (12) @(posedge clk); #1;
    chk("b_post_reset_quiet", b_out_valid, 0);

    chk("a_queue_drained", qa_res.size(), 0);
    chk("b_queue_drained", qb_res.size(), 0);
    chk("c_queue_drained", qc_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
